// File: rtl/b4_srcv.sv
// Serial-in/parallel-out receiver: assembles WIDTH serial bits from a sync strobe into q with a valid pulse; latency WIDTH cycles.
// No backpressure (one bit accepted every clk). Optional B4_SRCV_PARITY_EN appends an even-parity bit (latency WIDTH+1, adds perr).
module b4_srcv #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             err
`ifdef B4_SRCV_PARITY_EN
  ,
  output logic             perr
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef B4_SRCV_PARITY_EN
    ,
    PAR
`endif
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [WIDTH-1:0] q_nx;
  logic             valid_nx, busy_nx, err_nx;
`ifdef B4_SRCV_PARITY_EN
  logic             perr_nx;
`endif

  // Writes frame bit k into its word position according to MSB_FIRST.
  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] w,
                                             input logic [CW-1:0]    k,
                                             input logic             b);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < WIDTH; i++) begin
      if ((MSB_FIRST ? (WIDTH - 1 - i) : i) == int'(k)) r[i] = b;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      q     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
`ifdef B4_SRCV_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
      q     <= q_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
      err   <= err_nx;
`ifdef B4_SRCV_PARITY_EN
      perr  <= perr_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    q_nx     = q;
    valid_nx = 1'b0;
    busy_nx  = busy;
    err_nx   = 1'b0;
`ifdef B4_SRCV_PARITY_EN
    perr_nx  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sync) begin
          sreg_nx  = place('0, '0, sin);
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
          busy_nx  = 1'b1;
        end
      end
      SHIFT: begin
        if (sync) begin
          // Resynchronise: the sync bit opens a fresh frame, partial word dropped.
          err_nx  = 1'b1;
          sreg_nx = place('0, '0, sin);
          cnt_nx  = CW'(1);
        end else begin
          sreg_nx = place(sreg, cnt, sin);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef B4_SRCV_PARITY_EN
            cnt_nx   = cnt + CW'(1);
            state_nx = PAR;
`else
            q_nx     = sreg_nx;
            valid_nx = 1'b1;
            busy_nx  = 1'b0;
            cnt_nx   = '0;
            state_nx = IDLE;
`endif
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
`ifdef B4_SRCV_PARITY_EN
      PAR: begin
        if (sync) begin
          err_nx   = 1'b1;
          sreg_nx  = place('0, '0, sin);
          cnt_nx   = CW'(1);
          state_nx = SHIFT;
        end else begin
          q_nx     = sreg;
          valid_nx = 1'b1;
          perr_nx  = ^{sreg, sin};
          busy_nx  = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_b4_srcv.sv
// Bench for b4_srcv: scoreboarded frames on an LSB-first and an MSB-first instance.
module tb_b4_srcv;
  localparam int W = 4;
`ifdef B4_SRCV_PARITY_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sync = 1'b0;
  logic [W-1:0] qa, qb;
  logic va, vb, ba, bb, ea, eb;
`ifdef B4_SRCV_PARITY_EN
  logic pa, pb;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] expq[$];
  logic         expp[$];
  logic         ssy[$];
  logic         ssi[$];

  always #5 clk = ~clk;

  b4_srcv #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .sin(sin), .sync(sync),
    .q(qa), .valid(va), .busy(ba), .err(ea)
`ifdef B4_SRCV_PARITY_EN
    , .perr(pa)
`endif
  );

  b4_srcv #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .sin(sin), .sync(sync),
    .q(qb), .valid(vb), .busy(bb), .err(eb)
`ifdef B4_SRCV_PARITY_EN
    , .perr(pb)
`endif
  );

  // Drives one cycle at the falling edge; returns 1ns after the next rising edge.
  task automatic cyc(input logic r, input logic sy, input logic si);
    @(negedge clk);
    rst  = r;
    sync = sy;
    sin  = si;
    @(posedge clk);
    #1;
  endtask

  // Queues a frame (bit k = b[k]) and the word/parity result it must produce.
  function automatic void push_frame(input logic [W-1:0] b, input logic par_ok);
    for (int k = 0; k < W; k++) begin
      ssy.push_back(k == 0);
      ssi.push_back(b[k]);
    end
`ifdef B4_SRCV_PARITY_EN
    ssy.push_back(1'b0);
    ssi.push_back((^b) ^ ~par_ok);
`endif
    expq.push_back(b);
    expp.push_back(~par_ok);
  endfunction

  task automatic test_reset;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if ({qa, va, ba, ea} !== '0) begin
      failures++;
      $display("FAIL reset_state got q=%b v=%b b=%b e=%b want all 0", qa, va, ba, ea);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, i[0]);
      checks++;
      if ({qa, va, ba, ea} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got q=%b v=%b b=%b e=%b want all 0", i, qa, va, ba, ea);
      end
    end
  endtask

  task automatic test_single;
    logic [W-1:0] e;
    logic ep;
    push_frame(4'b0001, 1'b1);
    for (int t = 1; t <= LAT; t++) begin
      cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      checks++;
      if (va !== (t == LAT) || ba !== (t != LAT)) begin
        failures++;
        $display("FAIL single_timing t=%0d got v=%b b=%b want v=%b b=%b", t, va, ba, t == LAT, t != LAT);
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e) begin
          failures++;
          $display("FAIL single_q got %b want %b", qa, e);
        end
`ifdef B4_SRCV_PARITY_EN
        checks++;
        if (pa !== ep) begin
          failures++;
          $display("FAIL single_perr got %b want %b", pa, ep);
        end
`endif
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (va !== 1'b0 || qa !== 4'b0001) begin
      failures++;
      $display("FAIL single_hold got v=%b q=%b want v=0 q=0001", va, qa);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    logic ep;
    push_frame(4'b1101, 1'b1);
    push_frame(4'b0110, 1'b1);
    for (int t = 1; t <= 2 * LAT; t++) begin
      cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      checks++;
      if (va !== (t % LAT == 0)) begin
        failures++;
        $display("FAIL b2b_valid t=%0d got %b want %b", t, va, t % LAT == 0);
      end
      if (t % LAT != 0) begin
        checks++;
        if (ba !== 1'b1) begin
          failures++;
          $display("FAIL b2b_busy t=%0d got %b want 1", t, ba);
        end
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e) begin
          failures++;
          $display("FAIL b2b_q t=%0d got %b want %b", t, qa, e);
        end
      end
    end
  endtask

  task automatic test_framing;
    logic [W-1:0] e;
    logic ep;
    ssy.push_back(1'b1); ssi.push_back(1'b1);
    ssy.push_back(1'b0); ssi.push_back(1'b1);
    push_frame(4'b0100, 1'b1);
    for (int t = 1; t <= 2 + LAT + 1; t++) begin
      if (ssy.size() > 0) cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      else cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (ea !== (t == 3) || va !== (t == 2 + LAT)) begin
        failures++;
        $display("FAIL framing t=%0d got e=%b v=%b want e=%b v=%b", t, ea, va, t == 3, t == 2 + LAT);
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e) begin
          failures++;
          $display("FAIL framing_q got %b want %b", qa, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] e;
    logic ep;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (va !== 1'b0 || ba !== 1'b0 || qa !== '0) begin
        failures++;
        $display("FAIL reset_mid i=%0d got v=%b b=%b q=%b want 0 0 0000", i, va, ba, qa);
      end
    end
    push_frame(4'b1111, 1'b1);
    for (int t = 1; t <= LAT; t++) begin
      cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      checks++;
      if (va !== (t == LAT)) begin
        failures++;
        $display("FAIL reset_mid_valid t=%0d got %b want %b", t, va, t == LAT);
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e) begin
          failures++;
          $display("FAIL reset_mid_q got %b want %b", qa, e);
        end
      end
    end
  endtask

  task automatic test_msb_first;
    logic [W-1:0] e, eb_rev;
    logic ep;
    push_frame(4'b0001, 1'b1);
    eb_rev = 4'b1000;
    for (int t = 1; t <= LAT; t++) begin
      cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      checks++;
      if (vb !== (t == LAT)) begin
        failures++;
        $display("FAIL msb_valid t=%0d got %b want %b", t, vb, t == LAT);
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e || qb !== eb_rev) begin
          failures++;
          $display("FAIL msb_q got a=%b b=%b want a=%b b=%b", qa, qb, e, eb_rev);
        end
      end
    end
  endtask

`ifdef B4_SRCV_PARITY_EN
  task automatic test_parity;
    logic [W-1:0] e;
    logic ep;
    push_frame(4'b1101, 1'b0);
    push_frame(4'b1101, 1'b1);
    for (int t = 1; t <= 2 * LAT; t++) begin
      cyc(1'b0, ssy.pop_front(), ssi.pop_front());
      checks++;
      if (va !== (t % LAT == 0)) begin
        failures++;
        $display("FAIL parity_valid t=%0d got %b want %b", t, va, t % LAT == 0);
      end
      if (va) begin
        e = expq.pop_front();
        ep = expp.pop_front();
        checks++;
        if (qa !== e || pa !== ep) begin
          failures++;
          $display("FAIL parity t=%0d got q=%b perr=%b want q=%b perr=%b", t, qa, pa, e, ep);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_framing;
    test_reset_mid;
    test_msb_first;
`ifdef B4_SRCV_PARITY_EN
    test_parity;
`endif
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
